// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- pixel timing source for the VGA pipeline.
//
// Divides clk into a one-clock pixel enable (pclk_tick) and runs the
// horizontal/vertical raster counters, decoding sync pulses, display enable
// and visible pixel coordinates for the downstream colour generators.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   pclk_tick    out  one-clock pixel enable, high every CLK_DIV clocks
//   h_sync       out  horizontal sync, active-low
//   v_sync       out  vertical sync, active-low
//   DE           out  display enable, high inside the visible window
//   x_pixel      out  visible column, 0 outside the visible window
//   y_pixel      out  visible row, 0 outside the visible window
//   frame_start  out  one-clock pulse when the raster wraps to (0,0)
//   frame_cnt    out  frames completed (mod 256); only with VGA_FRAME_CNT_EN
//
// Optional feature macro: VGA_FRAME_CNT_EN adds the frame_cnt port/register.
//
// Every output is registered and reflects the counter state of the previous
// clock, so the first clock after reset release already shows pixel (0,0).

module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pclk_tick,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Refuse to elaborate configurations the 10-bit counters cannot represent.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Window bounds can reach 1024, so decode is done on 11-bit values.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [3:0]  div_q,  div_d;
  logic        tick_q, tick_d;
  logic [9:0]  h_q,    h_d;
  logic [9:0]  v_q,    v_d;
  logic        hs_q,   hs_d;
  logic        vs_q,   vs_d;
  logic        de_q,   de_d;
  logic [9:0]  x_q,    x_d;
  logic [9:0]  y_q,    y_d;
  logic        fs_q,   fs_d;
  logic [10:0] h_ext_s;
  logic [10:0] v_ext_s;
  logic        h_vis_s;
  logic        v_vis_s;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  fc_q,   fc_d;
`endif

  // Next-state logic: divider, raster counters and output decode.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    h_d    = h_q;
    v_d    = v_q;
    fs_d   = 1'b0;

    // Divider wraps by equality so CLK_DIV=1 keeps it pinned at 0.
    if (div_q == DIV_LAST) begin
      div_d = 4'd0;
    end else begin
      div_d = div_q + 4'd1;
    end
    tick_d = (div_q == DIV_LAST);

    // The raster advances only on the registered tick.
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d  = 10'd0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end

    // Outputs describe the current counter values, registered below.
    h_ext_s = {1'b0, h_q};
    v_ext_s = {1'b0, v_q};
    h_vis_s = (h_ext_s < H_VIS_END);
    v_vis_s = (v_ext_s < V_VIS_END);
    de_d    = h_vis_s && v_vis_s;
    x_d     = de_d ? h_q : 10'd0;
    y_d     = de_d ? v_q : 10'd0;
    hs_d    = !((h_ext_s >= HS_START) && (h_ext_s < HS_END));
    vs_d    = !((v_ext_s >= VS_START) && (v_ext_s < VS_END));

`ifdef VGA_FRAME_CNT_EN
    // Counts on the same edge that raises frame_start; wraps naturally.
    if (fs_d) begin
      fc_d = fc_q + 8'd1;
    end else begin
      fc_d = fc_q;
    end
`endif
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= 4'd0;
      tick_q <= 1'b0;
      h_q    <= 10'd0;
      v_q    <= 10'd0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      x_q    <= 10'd0;
      y_q    <= 10'd0;
      fs_q   <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      fc_q   <= 8'd0;
`endif
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
`ifdef VGA_FRAME_CNT_EN
      fc_q   <= fc_d;
`endif
    end
  end

  assign pclk_tick   = tick_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign DE          = de_q;
  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign frame_start = fs_q;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = fc_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen. Two instances share clk/reset: one with
// the default 640x480 timing (CLK_DIV=4) and a miniature raster with
// CLK_DIV=1 so that full frames and the 8-bit frame counter wrap fit the run.
// Expected outputs come from an arithmetic model: after k clocks since reset
// release the pixel position is the number of ticks elapsed, unfolded into
// (h, v) by division/modulo over the raster size.

module tb_vga_sync_gen;

  localparam int FD = 4, FHV = 640, FHFP = 16, FHS = 96, FHBP = 48;
  localparam int FVV = 480, FVFP = 10, FVS = 2, FVBP = 33;
  localparam int SD = 1, SHV = 10, SHFP = 2, SHS = 3, SHBP = 2;
  localparam int SVV = 6, SVFP = 1, SVS = 2, SVBP = 1;
  localparam int SFRAME = (SHV + SHFP + SHS + SHBP) * (SVV + SVFP + SVS + SVBP);

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       f_tick, f_hs, f_vs, f_de, f_fs;
  logic [9:0] f_x, f_y;
  logic [7:0] f_fc;
  logic       s_tick, s_hs, s_vs, s_de, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  exp_t q_full[$];
  exp_t q_small[$];
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_full (
    .clk(clk), .reset(reset), .pclk_tick(f_tick), .h_sync(f_hs),
    .v_sync(f_vs), .DE(f_de), .x_pixel(f_x), .y_pixel(f_y),
    .frame_start(f_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(f_fc)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_VISIBLE(SVV), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP)
  ) u_small (
    .clk(clk), .reset(reset), .pclk_tick(s_tick), .h_sync(s_hs),
    .v_sync(s_vs), .DE(s_de), .x_pixel(s_x), .y_pixel(s_y),
    .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign f_fc = 8'd0;
  assign s_fc = 8'd0;
`endif

  // Expected outputs kk clocks after reset release (kk=0: reset values).
  function automatic exp_t model(input int kk, input int d,
                                 input int hv, input int hfp, input int hsw, input int hbp,
                                 input int vv, input int vfp, input int vsw, input int vbp);
    int   ht, vt, f, pb, pos, h, v, fr_now, fr_prev;
    exp_t e;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    f  = ht * vt;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (kk > 0) begin
      e.tick  = ((kk % d) == 0);
      pb      = (kk >= 2) ? (kk - 2) / d : 0;
      pos     = pb % f;
      h       = pos % ht;
      v       = pos / ht;
      e.de    = (h < hv) && (v < vv);
      e.x     = e.de ? 10'(h) : 10'd0;
      e.y     = e.de ? 10'(v) : 10'd0;
      e.hs    = !((h >= hv + hfp) && (h < hv + hfp + hsw));
      e.vs    = !((v >= vv + vfp) && (v < vv + vfp + vsw));
      fr_now  = ((kk - 1) / d) / f;
      fr_prev = (kk >= 2) ? ((kk - 2) / d) / f : 0;
      e.fs    = (fr_now != fr_prev);
      e.fc    = 8'(fr_now % 256);
    end
    return e;
  endfunction

  task automatic check_field(input string tag, input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s.%s cycle=%0d k=%0d: got %0d, expected %0d", tag, name, cyc, k, act, req);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic tick, input logic hs,
                           input logic vs, input logic de, input logic [9:0] x,
                           input logic [9:0] y, input logic fs, input logic [7:0] fc);
    check_field(tag, "pclk_tick",   int'(tick), int'(e.tick));
    check_field(tag, "h_sync",      int'(hs),   int'(e.hs));
    check_field(tag, "v_sync",      int'(vs),   int'(e.vs));
    check_field(tag, "DE",          int'(de),   int'(e.de));
    check_field(tag, "x_pixel",     int'(x),    int'(e.x));
    check_field(tag, "y_pixel",     int'(y),    int'(e.y));
    check_field(tag, "frame_start", int'(fs),   int'(e.fs));
`ifdef VGA_FRAME_CNT_EN
    check_field(tag, "frame_cnt",   int'(fc),   int'(e.fc));
`else
    if (fc != 8'd0) begin
      total++;
      bad++;
      $display("FAIL %s.frame_cnt_tie: got %0d, expected 0", tag, fc);
    end
`endif
  endtask

  // One clock: action 0 = run/hold, 1 = assert reset between edges, 2 = release.
  task automatic step(input int action);
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) k++;
    if (action == 2) reset = 1'b0;
    if (action == 1) begin
      #($urandom_range(1, 3));
      reset = 1'b1;
      k = 0;
    end
    q_full.push_back(model(k, FD, FHV, FHFP, FHS, FHBP, FVV, FVFP, FVS, FVBP));
    q_small.push_back(model(k, SD, SHV, SHFP, SHS, SHBP, SVV, SVFP, SVS, SVBP));
  endtask

  // Monitor: pops one expectation per instance each clock, on the falling edge.
  initial begin : monitor
    exp_t ef, es;
    forever begin
      @(negedge clk);
      if ((q_full.size() == 0) || (q_small.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow cycle=%0d: got empty queue, expected an entry", cyc);
      end else begin
        ef = q_full.pop_front();
        es = q_small.pop_front();
        check_dut("full",  ef, f_tick, f_hs, f_vs, f_de, f_x, f_y, f_fs, f_fc);
        check_dut("small", es, s_tick, s_hs, s_vs, s_de, s_x, s_y, s_fs, s_fc);
      end
    end
  end

  // Stimulus: reset, one full default line, random mid-frame resets, long run.
  initial begin : stimulus
    reset = 1'b1;
    step(0);
    step(0);
    step(2);
    for (int i = 0; i < 3300; i++) step(0);
    for (int r = 0; r < 4; r++) begin
      int run_len, hold;
      run_len = int'($urandom_range(100, 1500));
      hold    = int'($urandom_range(0, 2));
      for (int i = 0; i < run_len; i++) step(0);
      step(1);
      for (int i = 0; i < hold; i++) step(0);
      step(2);
    end
    // Enough small-raster frames to wrap an 8-bit frame counter.
    for (int i = 0; i < 257 * SFRAME + 60; i++) step(0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
